multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter LW_WAIT, default 0, meaning extra cycles MEM_RD dwells before WB_MEM (0..15).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports opcode  in  6 (IR[31:26]) and funct  in  6 (IR[5:0]).
REQ-005 SHALL have port zero  in  1  ALU zero flag.
REQ-006 SHALL have outputs ir_we, pc_we, mem_re, mem_we, reg_we, each out 1, as active-high strobes.
REQ-007 SHALL have port pc_src  out  2: 0 ALU result, 1 branch target register, 2 jump target, 3 rs (jr).
REQ-008 SHALL have port ext_src  out  1: extend-unit select, 1 sign-extend, 0 zero-extend.
REQ-009 SHALL have port alu_src_b  out  2: 0 rt, 1 constant 4, 2 extended imm, 3 extended imm<<2.
REQ-010 SHALL have port alu_op  out  2: 0 add, 1 sub, 2 funct-decoded, 3 opcode-decoded logic.
REQ-011 SHALL have ports reg_dst  out  2 (0 rt, 1 rd, 2 $31) and wb_sel  out  2 (0 ALU out, 1 MDR, 2 PC, 3 imm<<16).
REQ-012 SHALL have ports illegal  out  1 (one-cycle pulse) and state  out  4 (debug).

Function
REQ-013 SHALL register state; outputs combinational from state, opcode, funct, zero; any output not listed for a state is 0.
REQ-014 FETCH(0): mem_re=1, ir_we=1, pc_we=1, alu_src_b=1, pc_src=0; next DECODE.
REQ-015 DECODE(1): alu_src_b=3, alu_op=0, ext_src=1 (branch target precompute); next by opcode per REQ-016.
REQ-016 Dispatch: 000000 with funct 001000 -> JR; other 000000 -> EXEC_R; 001000/001001/001100/001101/001110 -> EXEC_I; 001111 -> WB_LUI; 100011/101011 -> MEM_ADDR; 000100/000101 -> BRANCH; 000010/000011 -> JUMP; any other opcode -> FETCH with illegal=1 in the DECODE cycle.
REQ-017 EXEC_R(2): alu_op=2, alu_src_b=0; next WB_R(3): reg_we=1, reg_dst=1, wb_sel=0; next FETCH.
REQ-018 EXEC_I(4): alu_src_b=2; ext_src=1 for 001000/001001, 0 for 001100/001101/001110; alu_op=0 for add forms, 3 for logic forms; next WB_I(5): reg_we=1, reg_dst=0, wb_sel=0; next FETCH.
REQ-019 WB_LUI(6): reg_we=1, reg_dst=0, wb_sel=3; next FETCH.
REQ-020 MEM_ADDR(7): alu_src_b=2, ext_src=1, alu_op=0; next MEM_RD(8) for lw, MEM_WR(9) for sw.
REQ-021 MEM_RD: mem_re=1; dwell exactly LW_WAIT+1 cycles via 4-bit counter cleared on entry; next WB_MEM(10): reg_we=1, reg_dst=0, wb_sel=1; next FETCH.
REQ-022 MEM_WR: mem_we=1 for one cycle; next FETCH.
REQ-023 BRANCH(11): alu_op=1, alu_src_b=0, pc_src=1; pc_we=(beq&zero)|(bne&~zero); next FETCH.
REQ-024 JUMP(12): pc_we=1, pc_src=2; for jal also reg_we=1, reg_dst=2, wb_sel=2; next FETCH.
REQ-025 JR(13): pc_we=1, pc_src=3; next FETCH.
REQ-026 Unused encodings 14,15 SHALL go to FETCH next cycle with all outputs 0.
REQ-027 Cycle counts (no stall, LW_WAIT=0): R/I 4, lui/beq/bne/j/jal/jr 3, sw 4, lw 5, illegal 2.

Reset
REQ-028 While rst=1: state<=FETCH, counter<=0, all outputs forced 0 regardless of state.
REQ-029 First FETCH strobes SHALL appear in the first cycle with rst=0; reset mid-instruction SHALL abandon it with no further strobes.

Configuration
REQ-030 With MC_STALL_EN defined: input mem_ready (1) added; FETCH, MEM_RD, MEM_WR hold while mem_ready=0; ir_we/pc_we/mem_we asserted only when mem_ready=1; MEM_RD exits only when counter done and mem_ready=1.
REQ-031 Without MC_STALL_EN: no mem_ready port; memory treated as always ready.

Verification
REQ-032 rst high 3 cycles, release -> all outputs 0 during reset; cycle 1 after release state=0, ir_we=pc_we=mem_re=1.
REQ-033 Opcode 001101 (ori) -> EXEC_I with ext_src=0, alu_op=3; WB_I reg_we=1, reg_dst=0; 4 cycles total.
REQ-034 beq with zero=1 then zero=0 -> BRANCH pc_we=1 then 0, pc_src=1 both times.
REQ-035 lw with LW_WAIT=3 -> mem_re high 4 cycles in MEM_RD, then WB_MEM wb_sel=1; 8 cycles total.
REQ-036 Opcode 111111 -> illegal=1 for one DECODE cycle, state=0 next; rst asserted in MEM_ADDR -> no mem strobe, FETCH after release.
REQ-037 MC_STALL_EN, mem_ready=0 for 2 cycles in FETCH -> state stays 0, ir_we=0 until mem_ready=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS-style datapath.
// State is registered; all control outputs decode combinationally from
// state, opcode, funct and zero, and are forced low while rst is high.
// Optional feature macro MC_STALL_EN adds a mem_ready input that holds
// FETCH, MEM_RD and MEM_WR until memory is ready.
module multicycle_ctrl #(
    parameter int LW_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
`ifdef MC_STALL_EN
    input  logic       mem_ready,
`endif
    output logic       ir_we,
    output logic       pc_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       reg_we,
    output logic [1:0] pc_src,
    output logic       ext_src,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        WB_LUI   = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WR   = 4'd9,
        WB_MEM   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        JR       = 4'd13
    } st_t;

    localparam logic [3:0] LW_LAST = LW_WAIT[3:0];

    st_t        st;
    logic [3:0] cnt;
    logic       rdy;
    st_t        dec_nxt;
    logic       dec_ill;

`ifdef MC_STALL_EN
    assign rdy = mem_ready;
`else
    assign rdy = 1'b1;
`endif

    // Opcode dispatch out of DECODE; unknown opcodes return to FETCH and flag illegal
    always_comb begin
        dec_nxt = FETCH;
        dec_ill = 1'b0;
        case (opcode)
            6'b000000: dec_nxt = (funct == 6'b001000) ? JR : EXEC_R;
            6'b001000, 6'b001001, 6'b001100,
            6'b001101, 6'b001110: dec_nxt = EXEC_I;
            6'b001111: dec_nxt = WB_LUI;
            6'b100011, 6'b101011: dec_nxt = MEM_ADDR;
            6'b000100, 6'b000101: dec_nxt = BRANCH;
            6'b000010, 6'b000011: dec_nxt = JUMP;
            default: dec_ill = 1'b1;
        endcase
    end

    // State register and MEM_RD dwell counter
    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= FETCH;
            cnt <= 4'd0;
        end else begin
            case (st)
                FETCH:    if (rdy) st <= DECODE;
                DECODE:   st <= dec_nxt;
                EXEC_R:   st <= WB_R;
                EXEC_I:   st <= WB_I;
                MEM_ADDR: begin
                    cnt <= 4'd0;
                    if (opcode == 6'b100011)      st <= MEM_RD;
                    else if (opcode == 6'b101011) st <= MEM_WR;
                    else                          st <= FETCH;
                end
                MEM_RD: begin
                    // counter saturates at the last dwell cycle, then waits for ready
                    if (cnt == LW_LAST) begin
                        if (rdy) st <= WB_MEM;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                MEM_WR:   if (rdy) st <= FETCH;
                default:  st <= FETCH;
            endcase
        end
    end

    // Control decode from current state; everything low during reset
    always_comb begin
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        pc_src    = 2'd0;
        ext_src   = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        reg_dst   = 2'd0;
        wb_sel    = 2'd0;
        illegal   = 1'b0;
        state     = 4'd0;
        if (!rst) begin
            state = st;
            case (st)
                FETCH: begin
                    mem_re    = 1'b1;
                    ir_we     = rdy;
                    pc_we     = rdy;
                    alu_src_b = 2'd1;
                end
                DECODE: begin
                    alu_src_b = 2'd3;
                    ext_src   = 1'b1;
                    illegal   = dec_ill;
                end
                EXEC_R: alu_op = 2'd2;
                WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = 2'd1;
                end
                EXEC_I: begin
                    alu_src_b = 2'd2;
                    // add forms sign-extend and add; logic forms zero-extend
                    if (opcode == 6'b001000 || opcode == 6'b001001) begin
                        ext_src = 1'b1;
                    end else begin
                        alu_op = 2'd3;
                    end
                end
                WB_I:   reg_we = 1'b1;
                WB_LUI: begin
                    reg_we = 1'b1;
                    wb_sel = 2'd3;
                end
                MEM_ADDR: begin
                    alu_src_b = 2'd2;
                    ext_src   = 1'b1;
                end
                MEM_RD: mem_re = 1'b1;
                MEM_WR: mem_we = rdy;
                WB_MEM: begin
                    reg_we = 1'b1;
                    wb_sel = 2'd1;
                end
                BRANCH: begin
                    alu_op = 2'd1;
                    pc_src = 2'd1;
                    pc_we  = (opcode == 6'b000100 &&  zero) ||
                             (opcode == 6'b000101 && !zero);
                end
                JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = 2'd2;
                    if (opcode == 6'b000011) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wb_sel  = 2'd2;
                    end
                end
                JR: begin
                    pc_we  = 1'b1;
                    pc_src = 2'd3;
                end
                default: ;
            endcase
        end
    end

endmodule
